// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_pkg
// Purpose  : Shared types for the iterative multiply/divide unit:
//            operation encoding, controller state encoding and the
//            iteration-counter width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

  // Operation encoding as presented on the op port.
  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,  // low word of signed product
    OP_MULH = 2'b01,  // high word of signed product
    OP_DIV  = 2'b10,  // signed quotient, truncated toward zero
    OP_REM  = 2'b11   // signed remainder, sign of dividend
  } op_e;

  // Controller states.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Counter must be able to hold the value w itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/negate_w.sv
`default_nettype none
// ============================================================================
// Module   : negate_w
// Purpose  : Parametrised two's-complement negation (o_y = -i_a).
// Ports    : i_a [WIDTH-1:0] operand in
//            o_y [WIDTH-1:0] negated value out
// Revision : 1.0 - initial release
// ============================================================================
module negate_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = ~i_a + 1'b1;

endmodule
`default_nettype wire

// File: rtl/multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_seq
// Purpose  : Iterative signed MUL / MULH / DIV / REM unit with valid/ready
//            handshakes. One radix-2 datapath: shift-add for multiply,
//            non-restoring for divide, WIDTH iterations per operation.
// Config   : MULTDIV_SEQ_EARLY_OUT_EN - when defined, a zero operand skips
//            the iteration phase (result ready two edges after accept).
// Ports    : clock, reset_n         clock, async active-low reset
//            in_valid/in_ready      request handshake
//            op[1:0]                00 MUL, 01 MULH, 10 DIV, 11 REM
//            operand_a/operand_b    signed operands (WIDTH bits)
//            out_valid/out_ready    result handshake
//            result[WIDTH-1:0]      signed result
//            exception              overflow / divide-by-zero flag
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             exception
);

  localparam int              CW     = cnt_width(WIDTH);
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_e               r_state, w_state_nxt;
  op_e                  r_op;
  logic [WIDTH-1:0]     r_a, r_b;          // operands as sampled at accept
  logic [WIDTH-1:0]     r_mag_a, r_mag_b;  // unsigned magnitudes
  logic [WIDTH:0]       r_hi;              // product high half / partial remainder
  logic [WIDTH-1:0]     r_lo;              // multiplier-product low / dividend-quotient
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_result;
  logic                 r_exc;

  logic                 w_is_div, w_zero, w_last, w_sa, w_sb;
  logic [WIDTH-1:0]     w_neg_a, w_neg_b, w_mag_a, w_mag_b;
  logic [WIDTH:0]       w_msum, w_dshift, w_dstep, w_drest;
  logic [2*WIDTH-1:0]   w_prod, w_neg_prod, w_sprod;
  logic [WIDTH-1:0]     w_neg_q, w_quot, w_neg_r, w_rem;
  logic                 w_bzero, w_ovf;
  logic [WIDTH-1:0]     w_res;
  logic                 w_exc;

  assign w_is_div = r_op[1];
  assign w_sa     = r_a[WIDTH-1];
  assign w_sb     = r_b[WIDTH-1];
  assign w_zero   = (r_a == '0) || (r_b == '0);
  assign w_last   = (r_state == S_CALC) && (r_cnt == C_LAST);

  // ---------------------------------------------------------------- control
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_PREP;
      end
      S_PREP: begin
`ifdef MULTDIV_SEQ_EARLY_OUT_EN
        w_state_nxt = w_zero ? S_FIX : S_CALC;
`else
        w_state_nxt = S_CALC;
`endif
      end
      S_CALC: if (w_last) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- magnitude forming
  negate_w #(.WIDTH(WIDTH)) u_neg_a (.i_a(r_a), .o_y(w_neg_a));
  negate_w #(.WIDTH(WIDTH)) u_neg_b (.i_a(r_b), .o_y(w_neg_b));
  assign w_mag_a = w_sa ? w_neg_a : r_a;
  assign w_mag_b = w_sb ? w_neg_b : r_b;

  // ------------------------------------------------------------ iteration
  // Multiply: add |A| when the multiplier LSB is set, then shift {hi,lo} right.
  assign w_msum = r_hi + (r_lo[0] ? {1'b0, r_mag_a} : '0);

  // Divide: shift {R,Q} left, then add or subtract |B| depending on the sign
  // of the previous remainder. With |B| <= 2^(WIDTH-1) the remainder always
  // fits WIDTH+1 signed bits. The last iteration folds in the restore step.
  assign w_dshift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_dstep  = r_hi[WIDTH] ? (w_dshift + {1'b0, r_mag_b})
                                : (w_dshift - {1'b0, r_mag_b});
  assign w_drest  = (w_last && w_dstep[WIDTH]) ? (w_dstep + {1'b0, r_mag_b}) : w_dstep;

  // ------------------------------------------------------- sign fix-up
  assign w_prod = {r_hi[WIDTH-1:0], r_lo};
  negate_w #(.WIDTH(2*WIDTH)) u_neg_p (.i_a(w_prod), .o_y(w_neg_prod));
  negate_w #(.WIDTH(WIDTH))   u_neg_q (.i_a(r_lo), .o_y(w_neg_q));
  negate_w #(.WIDTH(WIDTH))   u_neg_r (.i_a(r_hi[WIDTH-1:0]), .o_y(w_neg_r));
  assign w_sprod = (w_sa ^ w_sb) ? w_neg_prod : w_prod;
  assign w_quot  = (w_sa ^ w_sb) ? w_neg_q : r_lo;
  assign w_rem   = w_sa ? w_neg_r : r_hi[WIDTH-1:0];

  assign w_bzero = (r_b == '0);
  assign w_ovf   = (r_a == C_MIN) && (r_b == '1);

  always_comb begin
    w_res = '0;
    w_exc = 1'b0;
    case (r_op)
      OP_MUL: begin
        w_res = w_sprod[WIDTH-1:0];
        w_exc = (w_sprod[2*WIDTH-1:WIDTH] != {WIDTH{w_sprod[WIDTH-1]}});
      end
      OP_MULH: w_res = w_sprod[2*WIDTH-1:WIDTH];
      OP_DIV: begin
        w_exc = w_bzero | w_ovf;
        w_res = w_bzero ? '0 : (w_ovf ? r_a : w_quot);
      end
      OP_REM: begin
        w_exc = w_bzero | w_ovf;
        w_res = w_bzero ? r_a : (w_ovf ? '0 : w_rem);
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op     <= OP_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op <= op_e'(op);
          r_a  <= operand_a;
          r_b  <= operand_b;
        end
        S_PREP: begin
          r_mag_a <= w_mag_a;
          r_mag_b <= w_mag_b;
          r_hi    <= '0;
          r_cnt   <= '0;
          // A zero operand means a zero product/quotient/remainder; loading
          // zero here makes the skipped-iteration path produce it directly.
          r_lo    <= w_zero ? '0 : (w_is_div ? w_mag_a : w_mag_b);
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_is_div) begin
            r_hi <= w_drest;
            r_lo <= {r_lo[WIDTH-2:0], ~w_dstep[WIDTH]};
          end else begin
            r_hi <= {1'b0, w_msum[WIDTH:1]};
            r_lo <= {w_msum[0], r_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_result <= w_res;
          r_exc    <= w_exc;
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign exception = r_exc;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_seq
// Purpose  : Self-checking bench for multdiv_seq (WIDTH=32). Directed
//            vectors push expected results into a scoreboard queue; a
//            monitor pops and compares on each new result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         exc;
  } exp_t;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         exc;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         exception;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  exp_t exp_q[$];
  vec_t vecs[16];

  multdiv_seq #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .exception (exception)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULTDIV_SEQ_EARLY_OUT_EN
    if (a == '0 || b == '0) return 2;
`endif
    return W + 2;
  endfunction

  // Called at a negedge with the unit idle. Returns #1 after the edge where
  // out_valid was first seen high.
  task automatic issue(input vec_t v, input int idx);
    exp_t e;
    int   lat;
    e.res = v.res;
    e.exc = v.exc;
    exp_q.push_back(e);
    op = v.op; operand_a = v.a; operand_b = v.b; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    op = ~v.op; operand_a = ~v.a; operand_b = ~v.b;
    check($sformatf("accepted[%0d]", idx), 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check($sformatf("latency[%0d]", idx), 64'(lat), 64'(exp_latency(v.a, v.b)));
  endtask

  // Transfer the presented result (out_ready already high) and resync.
  task automatic xfer(input int idx);
    @(posedge clock);
    #1;
    check($sformatf("in_ready_after_xfer[%0d]", idx), {62'd0, in_ready, out_valid}, 64'd2);
    @(negedge clock);
  endtask

  // Scoreboard monitor: compare on each rising out_valid.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (out_valid && !prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: got res=%h exc=%b, nothing expected", result, exception);
        end else begin
          e = exp_q.pop_front();
          if (result !== e.res || exception !== e.exc) begin
            n_err++;
            $display("FAIL result[%0d]: got res=%h exc=%b want res=%h exc=%b",
                     n_out, result, exception, e.res, e.exc);
          end
        end
        n_out++;
      end
      prev = out_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t v;
    vecs[0]  = '{2'b00, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0}; // 7*-6
    vecs[1]  = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1}; // overflow
    vecs[2]  = '{2'b01, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 1'b0}; // MULH min*2
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0}; // -7/2
    vecs[4]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0}; // -7%2
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1}; // min/-1
    vecs[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1}; // min%-1
    vecs[7]  = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1}; // 5/0
    vecs[8]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1}; // 5%0
    vecs[9]  = '{2'b00, 32'h00000000, 32'h00001234, 32'h00000000, 1'b0}; // 0*x
    vecs[10] = '{2'b10, 32'h00000000, 32'h00000005, 32'h00000000, 1'b0}; // 0/5
    vecs[11] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0}; // MULH -1*-1
    vecs[12] = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 1'b0}; // MULH max*max
    vecs[13] = '{2'b11, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 1'b0}; // 100%-7
    vecs[14] = '{2'b10, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0}; // min/1
    vecs[15] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0}; // -1*-1

    reset_n = 1'b0; in_valid = 1'b0; op = 2'b00;
    operand_a = '0; operand_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result",    64'(result),    64'd0);
    check("reset_exception", 64'(exception), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i], i);
      xfer(i);
    end

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    v = '{2'b10, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0}; // 100/-7
    issue(v, 16);
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("bp_hold[%0d]", k),
            {29'd0, out_valid, in_ready, exception, result},
            {29'd0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF2});
    end
    out_ready = 1'b1;
    xfer(16);
    v = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1}; // max*max
    issue(v, 17);
    xfer(17);

    // Reset in the middle of the iteration phase.
    op = 2'b00; operand_a = 32'd3; operand_b = 32'd5; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clock);
    #1;
    check("busy_before_reset", {62'd0, in_ready, out_valid}, 64'd0);
    reset_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_result",    64'(result),    64'd0);
    check("midreset_exception", 64'(exception), 64'd0);
    check("midreset_in_ready",  64'(in_ready),  64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    v = '{2'b00, 32'h00000003, 32'h00000005, 32'h0000000F, 1'b0};
    issue(v, 18);
    xfer(18);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
